// File: rtl/ctrl_pkg.sv
// Shared types and constants for the decode-stage control unit: opcode
// names, matrix command encoding, FSM states and the registered control word.
package ctrl_pkg;

  localparam int ALU_OP_W = 4;

  // Opcode map (7-bit). Legal ranges are captured in op_is_legal() below.
  localparam logic [6:0] OP_NOP    = 7'h00;
  localparam logic [6:0] OP_ADD    = 7'h01;
  localparam logic [6:0] OP_SUB    = 7'h02;
  localparam logic [6:0] OP_AND    = 7'h03;
  localparam logic [6:0] OP_OR     = 7'h04;
  localparam logic [6:0] OP_XOR    = 7'h05;
  localparam logic [6:0] OP_SLL    = 7'h06;
  localparam logic [6:0] OP_SRL    = 7'h07;
  localparam logic [6:0] OP_SRA    = 7'h08;
  localparam logic [6:0] OP_SLT    = 7'h09;
  localparam logic [6:0] OP_SLTU   = 7'h0A;
  localparam logic [6:0] OP_ADDI   = 7'h11;
  localparam logic [6:0] OP_LUI    = 7'h1B;
  localparam logic [6:0] OP_LW     = 7'h20;
  localparam logic [6:0] OP_SW     = 7'h21;
  localparam logic [6:0] OP_BEQ    = 7'h3C;
  localparam logic [6:0] OP_BNE    = 7'h3D;
  localparam logic [6:0] OP_BLT    = 7'h3E;
  localparam logic [6:0] OP_BGE    = 7'h3F;
  localparam logic [6:0] OP_MATMUL = 7'h50;
  localparam logic [6:0] OP_LAM    = 7'h51;
  localparam logic [6:0] OP_LBM    = 7'h52;
  localparam logic [6:0] OP_LACC   = 7'h53;
  localparam logic [6:0] OP_RACC   = 7'h54;
  localparam logic [6:0] OP_J      = 7'h7E;
  localparam logic [6:0] OP_JR     = 7'h7F;

  // Command presented to the systolic matrix unit alongside each beat.
  typedef enum logic [2:0] {
    MX_NONE   = 3'd0,
    MX_MATMUL = 3'd1,
    MX_LAM    = 3'd2,
    MX_LBM    = 3'd3,
    MX_LACC   = 3'd4,
    MX_RACC   = 3'd5
  } mx_cmd_t;

  // S_RUN: normal issue. S_MX: expanding a matrix op into row beats.
  typedef enum logic {
    S_RUN = 1'b0,
    S_MX  = 1'b1
  } state_t;

  // Control word handed to the execute stage.
  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                jump;
    logic                branch;
    logic                write;
    logic                imm_sel;
    logic                wb_sel;
    logic                illegal;
  } ctrl_word_t;

  // True for every opcode the decoder recognises.
  function automatic logic op_is_legal(input logic [6:0] op);
    return op inside {[7'h00:7'h0A], 7'h11, [7'h13:7'h19], 7'h1B,
                      7'h20, 7'h21, [7'h3C:7'h3F], [7'h50:7'h54],
                      7'h7E, 7'h7F};
  endfunction

  // True for opcodes that write the register file.
  function automatic logic op_writes(input logic [6:0] op);
    return op inside {[7'h01:7'h0A], 7'h11, [7'h13:7'h19], 7'h1B, 7'h20};
  endfunction

endpackage

// File: rtl/ctrl_seq_op_decode.sv
// Purely combinational opcode decoder: produces the control word, flags
// matrix-unit opcodes and selects their matrix command.
module op_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  output ctrl_word_t word_o,
  output logic       is_mx_o,
  output mx_cmd_t    mx_cmd_o
);

  // Decode one opcode; illegal opcodes raise only the illegal flag.
  always_comb begin
    // NOTE: every output gets a default before any branch so that no path
    // through this block leaves a value unassigned, which would infer a latch.
    word_o   = '0;
    is_mx_o  = 1'b0;
    mx_cmd_o = MX_NONE;

    if (!op_is_legal(op_i)) begin
      word_o.illegal = 1'b1;
    end else begin
      // Load/store group uses a fixed ALU add; everything else passes the
      // low nibble straight through as the ALU operation.
      word_o.alu_op  = (op_i[6:4] == 3'b010) ? ALU_OP_W'(1) : op_i[3:0];
      word_o.jump    = &op_i[6:1];
      word_o.branch  = (op_i[6:4] == 3'b011);
      word_o.imm_sel = op_i[4] ^ op_i[5];
      word_o.wb_sel  = (op_i[6:4] == 3'b010);
      // Matrix ops are not in the write set, so their control word carries
      // write=0 and only preserves program order downstream.
      word_o.write   = op_writes(op_i);

      case (op_i)
        OP_MATMUL: mx_cmd_o = MX_MATMUL;
        OP_LAM:    mx_cmd_o = MX_LAM;
        OP_LBM:    mx_cmd_o = MX_LBM;
        OP_LACC:   mx_cmd_o = MX_LACC;
        OP_RACC:   mx_cmd_o = MX_RACC;
        default:   mx_cmd_o = MX_NONE;
      endcase
      is_mx_o = (mx_cmd_o != MX_NONE);
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// Decode-stage control unit. Registers the decoded control word behind a
// valid/ready handshake (1-cycle latency, 1 op/cycle) and expands matrix
// opcodes into a multi-beat row sequence toward the systolic matrix unit,
// stalling upstream until the sequence finishes.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter  int DIM   = 8,
  parameter  int ALU_W = 4,
  localparam int CNT_W = $clog2(3*DIM-1)
) (
  input  logic             clk,
  input  logic             rst,
  // Issue side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       op,
  // Execute side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ALU_W-1:0] alu_op,
  output logic             jump,
  output logic             branch,
  output logic             write,
  output logic             imm_sel,
  output logic             wb_sel,
  output logic             illegal,
  // Matrix unit side
  output mx_cmd_t          mx_cmd,
  output logic             mx_valid,
  input  logic             mx_ready,
  output logic [CNT_W-1:0] mx_row,
  output logic             mx_last,
  output logic             busy
);

  // Index of the final beat: matmul streams 3*DIM-2 skewed rows, the
  // load/read commands stream one beat per row.
  localparam logic [CNT_W-1:0] LAST_MATMUL = CNT_W'(3*DIM-3);
  localparam logic [CNT_W-1:0] LAST_ROW    = CNT_W'(DIM-1);

  ctrl_word_t       dec_word;
  logic             dec_is_mx;
  mx_cmd_t          dec_cmd;

  ctrl_word_t       word_q;
  logic             out_valid_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  mx_cmd_t          cmd_q,   cmd_d;

  logic             accept;
  logic             last_beat;

  op_decode u_op_decode (
    .op_i     (op),
    .word_o   (dec_word),
    .is_mx_o  (dec_is_mx),
    .mx_cmd_o (dec_cmd)
  );

  // Upstream may only issue while no matrix sequence runs and the output
  // register is empty or draining this cycle; held off during reset.
  assign in_ready  = ~rst & (state_q == S_RUN) & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;

  assign last_beat = (state_q == S_MX) &&
                     (cnt_q == ((cmd_q == MX_MATMUL) ? LAST_MATMUL : LAST_ROW));

  // Output register: load on accept, clear once consumed, hold under stall.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and process ordering cannot change the result.
    if (rst) begin
      out_valid_q <= 1'b0;
      word_q      <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      word_q      <= dec_word;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Matrix sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      cmd_q   <= MX_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
    end
  end

  // Matrix sequencer next state: start on an accepted matrix op, advance the
  // row on each accepted beat, return to S_RUN after the last beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;

    case (state_q)
      S_RUN: begin
        if (accept && dec_is_mx) begin
          state_d = S_MX;
          cnt_d   = '0;
          cmd_d   = dec_cmd;
        end
      end
      S_MX: begin
        if (mx_ready) begin
          if (last_beat) begin
            state_d = S_RUN;
            cnt_d   = '0;
            cmd_d   = MX_NONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
        cmd_d   = MX_NONE;
      end
    endcase
  end

  // Execute-side outputs come straight from the output register.
  assign out_valid = out_valid_q;
  assign alu_op    = ALU_W'(word_q.alu_op);
  assign jump      = word_q.jump;
  assign branch    = word_q.branch;
  assign write     = word_q.write;
  assign imm_sel   = word_q.imm_sel;
  assign wb_sel    = word_q.wb_sel;
  assign illegal   = word_q.illegal;

  // Matrix-side outputs; cmd_q is MX_NONE whenever the sequencer is idle.
  assign mx_valid  = (state_q == S_MX);
  assign busy      = (state_q == S_MX);
  assign mx_row    = cnt_q;
  assign mx_last   = last_beat;
  assign mx_cmd    = cmd_q;

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Registered instruction-control unit for the decode stage. Decodes a 7-bit opcode into ALU and pipeline control fields; latency is 1 cycle, with valid/ready handshakes on both sides.
- Matrix-unit opcodes (0x50–0x54) are also expanded into a multi-beat row sequence toward the systolic matrix unit. Upstream is stalled until the sequence completes.
- Sits between fetch/issue and the execute stage and matrix unit.

Parameters:
- DIM, 8, matrix dimension; sets the matrix beat counts.
- ALU_W, 4, ALU opcode width.
- CNT_W, $clog2(3*DIM-1), row/beat counter width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  opcode valid from issue
- in_ready  out  1  ctrl_seq accepts opcode this cycle
- op  in  7  opcode
- out_valid  out  1  control word valid
- out_ready  in  1  execute stage accepts control word
- alu_op  out  ALU_W  ALU operation
- jump, branch, write, imm_sel, wb_sel  out  1 each  pipeline control
- illegal  out  1  undefined opcode flag
- mx_cmd  out  3  matrix command (package enum)
- mx_valid  out  1  matrix beat valid
- mx_ready  in  1  matrix unit accepts beat
- mx_row  out  CNT_W  beat index
- mx_last  out  1  final beat of sequence
- busy  out  1  matrix sequence in progress

Behaviour:
- Reset: every registered output is 0, state is S_RUN, and counter is 0. in_ready is forced 0 while rst is high. Reset mid-sequence abandons the sequence; mx_valid is 0 on the cycle after reset.
- in_ready = (state==S_RUN) & (~out_valid | out_ready). This is combinational and gives 1 op/cycle throughput.
- Accept = in_valid & in_ready. On accept, the decoded word loads into the output register and out_valid=1 the next cycle.
- If out_ready=1 and there is no accept, out_valid clears. While out_valid & ~out_ready, the word holds stable.
- Decode for legal opcodes:
  - alu_op = 1 if op[6:4]==3'b010, else op[3:0].
  - jump = &op[6:1].
  - branch = op[6:4]==3'b011.
  - imm_sel = op[4]^op[5].
  - wb_sel = op[6:4]==3'b010.
  - write=1 for 0x01–0x0A, 0x11, 0x13–0x19, 0x1B, 0x20; else 0.
- Legal opcode set: 0x00–0x0A, 0x11, 0x13–0x19, 0x1B, 0x20, 0x21, 0x3C–0x3F, 0x50–0x54, 0x7E, 0x7F.
- Any other opcode gives illegal=1 and all other control fields 0, including alu_op. It does not start a matrix sequence.
- Matrix ops 0x50 matmul, 0x51 lam, 0x52 lbm, 0x53 lacc, 0x54 racc:
  - A normal control word is emitted with write=0 to keep program order. On accept, state goes to S_MX and counter=0.
  - mx_cmd is set to MX_MATMUL/MX_LAM/MX_LBM/MX_LACC/MX_RACC respectively.
- S_MX:
  - Drives mx_valid=1, busy=1, mx_row=counter, in_ready=0.
  - On each mx_ready, counter increments.
  - Beat count N = 3*DIM-2 for matmul, DIM for the others. mx_last = (counter==N-1).
  - On mx_last & mx_ready: counter←0, mx_valid←0, mx_cmd←MX_NONE, state←S_RUN. The next op can be accepted in the following cycle.
  - mx_valid high with mx_ready low holds mx_row, mx_cmd and mx_last stable.
- The S_MX sequence and out_valid handshake are independent: the matrix op's control word may drain while beats issue.
- In S_RUN: mx_valid=0, busy=0, mx_cmd=MX_NONE.
- Counter never exceeds N-1; there is no wrap in normal operation.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams (OP_NOP … OP_JR)
  - typedef enum logic[2:0] mx_cmd_t: MX_NONE=0, MX_MATMUL=1, MX_LAM=2, MX_LBM=3, MX_LACC=4, MX_RACC=5
  - state enum {S_RUN, S_MX}
  - packed ctrl_word_t struct (alu_op, jump, branch, write, imm_sel, wb_sel, illegal)
- Sub-module op_decode: purely combinational opcode → ctrl_word_t, plus is_mx and mx_cmd. ctrl_seq adds registers, handshakes and the FSM.

Test Plan:
- Reset, then op=0x01, in_valid=1, out_ready=1 → next cycle out_valid=1, write=1, alu_op=1, imm_sel=0, illegal=0.
- Back-to-back 0x11, 0x20, 0x3D, 0x7E with out_ready=1:
  - 0x11 → imm_sel=1, write=1.
  - 0x20 → wb_sel=1, alu_op=1.
  - 0x3D → branch=1, write=0.
  - 0x7E → jump=1.
  - One word per cycle, in_ready held 1.
- out_ready=0 for 3 cycles with op=0x02 pending → word stable, in_ready=0. Release → new op accepted the same cycle.
- op=0x52, DIM=8, mx_ready=1:
  - busy=1 for 8 cycles; mx_row counts 0..7; mx_last=1 only at row 7; in_ready=0 throughout.
  - Next op accepted the cycle after.
- op=0x50, DIM=8, mx_ready toggling 1/0 → exactly 22 beats accepted, mx_row and mx_cmd held while stalled.
- op=0x30 → illegal=1, all fields 0, no sequence. Assert rst at row 3 of an lam sequence → next cycle mx_valid=0, busy=0, out_valid=0.
